// File: rtl/mips_multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcodes, functs,
// FSM state encodings and the datapath mux/ALU select codes.
package mips_multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } aluop_t;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_HALT    = 4'd12
    } state_t;

endpackage

// File: rtl/mips_multicycle_control_alu_decoder.sv
// ALU decoder: maps the FSM's aluop class plus the R-type funct field to the
// 3-bit ALU control code. Purely combinational.
module mips_multicycle_control_alu_decoder
    import mips_multicycle_control_pkg::*;
(
    input  aluop_t      i_aluop,
    input  logic [5:0]  i_funct,
    output logic [2:0]  o_alucontrol
);

    always_comb begin
        o_alucontrol = ALU_ADD;
        case (i_aluop)
            ALUOP_ADD:  o_alucontrol = ALU_ADD;
            ALUOP_SUB:  o_alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alucontrol = ALU_ADD;
                    FN_SUB:  o_alucontrol = ALU_SUB;
                    FN_AND:  o_alucontrol = ALU_AND;
                    FN_OR:   o_alucontrol = ALU_OR;
                    FN_SLT:  o_alucontrol = ALU_SLT;
                    default: o_alucontrol = ALU_ADD;
                endcase
            end
            ALUOP_RSVD: o_alucontrol = ALU_ADD;
            default:    o_alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with datapath controls decoded combinationally from state.
module mips_multicycle_control
    import mips_multicycle_control_pkg::*;
#(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic [5:0] i_op,
    input  logic [5:0] i_funct,
    input  logic       i_zero,
    output logic       o_pcen,
    output logic       o_irwrite,
    output logic       o_iord,
    output logic       o_memwrite,
    output logic       o_memtoreg,
    output logic       o_regdst,
    output logic       o_regwrite,
    output logic       o_alusrca,
    output logic [1:0] o_alusrcb,
    output logic [1:0] o_pcsrc,
    output logic [2:0] o_alucontrol,
    output logic [3:0] o_state
);

    state_t     r_state;
    aluop_t     w_aluop;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_alu_en;
    logic [2:0] w_alu_dec;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= S_DECODE;
                S_DECODE: begin
                    case (i_op)
                        OP_LW, OP_SW: r_state <= S_MEMADR;
                        OP_RTYPE:     r_state <= S_EXECUTE;
                        OP_BEQ:       r_state <= S_BRANCH;
                        OP_ADDI:      r_state <= S_ADDIEX;
                        OP_J:         r_state <= S_JUMP;
                        default:      r_state <= ILLEGAL_TRAP ? S_HALT : S_FETCH;
                    endcase
                end
                S_MEMADR:  r_state <= (i_op == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:   r_state <= S_MEMWB;
                S_EXECUTE: r_state <= S_ALUWB;
                S_ADDIEX:  r_state <= S_ADDIWB;
                S_HALT:    r_state <= S_HALT;
                default:   r_state <= S_FETCH;
            endcase
        end
    end

    mips_multicycle_control_alu_decoder u_aludec (
        .i_aluop      (w_aluop),
        .i_funct      (i_funct),
        .o_alucontrol (w_alu_dec)
    );

    // Reset masks every control so an abandoned instruction cannot write back.
    always_comb begin
        w_aluop    = ALUOP_ADD;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_alu_en   = 1'b0;
        o_irwrite  = 1'b0;
        o_iord     = 1'b0;
        o_memwrite = 1'b0;
        o_memtoreg = 1'b0;
        o_regdst   = 1'b0;
        o_regwrite = 1'b0;
        o_alusrca  = 1'b0;
        o_alusrcb  = SRCB_B;
        o_pcsrc    = PCSRC_ALURES;
        if (!i_reset) begin
            w_alu_en = 1'b1;
            case (r_state)
                S_FETCH: begin
                    o_alusrcb = SRCB_FOUR;
                    o_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                end
                S_DECODE:  o_alusrcb = SRCB_IMMSH2;
                S_MEMADR: begin
                    o_alusrca = 1'b1;
                    o_alusrcb = SRCB_IMM;
                end
                S_MEMRD:   o_iord = 1'b1;
                S_MEMWB: begin
                    o_memtoreg = 1'b1;
                    o_regwrite = 1'b1;
                end
                S_MEMWR: begin
                    o_iord     = 1'b1;
                    o_memwrite = 1'b1;
                end
                S_EXECUTE: begin
                    o_alusrca = 1'b1;
                    w_aluop   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    o_regdst   = 1'b1;
                    o_regwrite = 1'b1;
                end
                S_BRANCH: begin
                    o_alusrca = 1'b1;
                    w_aluop   = ALUOP_SUB;
                    o_pcsrc   = PCSRC_ALUOUT;
                    w_branch  = 1'b1;
                end
                S_ADDIEX: begin
                    o_alusrca = 1'b1;
                    o_alusrcb = SRCB_IMM;
                end
                S_ADDIWB:  o_regwrite = 1'b1;
                S_JUMP: begin
                    o_pcsrc   = PCSRC_JUMP;
                    w_pcwrite = 1'b1;
                end
                default:   w_alu_en = 1'b0;
            endcase
        end
        o_pcen       = w_pcwrite | (w_branch & i_zero);
        o_alucontrol = w_alu_en ? w_alu_dec : 3'b000;
        o_state      = i_reset ? 4'd0 : r_state;
    end

endmodule
